// File: rtl/rv_mem_rmw_sequencer.sv
// Byte-masked request front end: reads, full writes and read-modify-write partial writes
// on a word-level memory command/result stream. Define RV_MEM_RMW_WRITE_ACK_EN to acknowledge writes.
module rv_mem_rmw_sequencer #(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 10,
  localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  // request side
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_op,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  input  logic [MASK_WIDTH-1:0] i_req_mask,
  // command stream to memory
  output logic                  o_cmd_valid,
  input  logic                  i_cmd_ready,
  output logic                  o_cmd_op,
  output logic [ADDR_WIDTH-1:0] o_cmd_addr,
  output logic [DATA_WIDTH-1:0] o_cmd_data,
  // result stream from memory
  input  logic                  i_res_valid,
  output logic                  o_res_ready,
  input  logic                  i_res_op,
  input  logic [ADDR_WIDTH-1:0] i_res_addr,
  input  logic [DATA_WIDTH-1:0] i_res_data,
  // response side
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [ADDR_WIDTH-1:0] o_resp_addr,
  output logic [DATA_WIDTH-1:0] o_resp_data
);

  localparam logic RV_MEM_READ  = 1'b0;
  localparam logic RV_MEM_WRITE = 1'b1;

`ifdef RV_MEM_RMW_WRITE_ACK_EN
  localparam logic ACK_EN = 1'b1;
`else
  localparam logic ACK_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_WR_ISSUE,
    S_RESP
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // latched request
  logic                    r_op,        w_op_nxt;
  logic [ADDR_WIDTH-1:0]   r_addr,      w_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_data,      w_data_nxt;
  logic [MASK_WIDTH-1:0]   r_mask,      w_mask_nxt;

  // registered outputs
  logic                    r_req_ready, w_req_ready_nxt;
  logic                    r_cmd_valid, w_cmd_valid_nxt;
  logic                    r_cmd_op,    w_cmd_op_nxt;
  logic [ADDR_WIDTH-1:0]   r_cmd_addr,  w_cmd_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_cmd_data,  w_cmd_data_nxt;
  logic                    r_res_ready, w_res_ready_nxt;
  logic                    r_resp_valid, w_resp_valid_nxt;
  logic [ADDR_WIDTH-1:0]   r_resp_addr, w_resp_addr_nxt;
  logic [DATA_WIDTH-1:0]   r_resp_data, w_resp_data_nxt;

  logic                    w_accept;
  logic                    w_mask_full;
  logic                    w_mask_zero;
  logic                    w_res_hit;
  logic [DATA_WIDTH-1:0]   w_merged;

  assign w_accept    = i_req_valid && r_req_ready;
  assign w_mask_full = &i_req_mask;
  assign w_mask_zero = ~|i_req_mask;

  // Only a read result for the outstanding address belongs to this transaction.
  assign w_res_hit = i_res_valid && r_res_ready &&
                     (i_res_op == RV_MEM_READ) && (i_res_addr == r_addr);

  always_comb begin
    w_merged = i_res_data;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      if (r_mask[i]) begin
        w_merged[8*i +: 8] = r_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a hold/default value first so no path through the
    // case statement leaves it unassigned, which would otherwise infer a latch.
    w_state_nxt      = r_state;
    w_op_nxt         = r_op;
    w_addr_nxt       = r_addr;
    w_data_nxt       = r_data;
    w_mask_nxt       = r_mask;
    w_cmd_valid_nxt  = r_cmd_valid;
    w_cmd_op_nxt     = r_cmd_op;
    w_cmd_addr_nxt   = r_cmd_addr;
    w_cmd_data_nxt   = r_cmd_data;
    w_resp_valid_nxt = r_resp_valid;
    w_resp_addr_nxt  = r_resp_addr;
    w_resp_data_nxt  = r_resp_data;

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_op_nxt   = i_req_op;
          w_addr_nxt = i_req_addr;
          w_data_nxt = i_req_data;
          w_mask_nxt = i_req_mask;
          if (i_req_op == RV_MEM_WRITE && w_mask_full) begin
            w_state_nxt     = S_WR_ISSUE;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_op_nxt    = RV_MEM_WRITE;
            w_cmd_addr_nxt  = i_req_addr;
            w_cmd_data_nxt  = i_req_data;
          end else if (i_req_op == RV_MEM_READ || !w_mask_zero) begin
            w_state_nxt     = S_RD_ISSUE;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_op_nxt    = RV_MEM_READ;
            w_cmd_addr_nxt  = i_req_addr;
          end else if (ACK_EN) begin
            // Empty write: nothing to store, acknowledge with a zero word.
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_addr_nxt  = i_req_addr;
            w_resp_data_nxt  = '0;
          end
        end
      end

      S_RD_ISSUE: begin
        if (i_cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_state_nxt     = S_RD_WAIT;
        end
      end

      S_RD_WAIT: begin
        if (w_res_hit) begin
          if (r_op == RV_MEM_READ) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_addr_nxt  = r_addr;
            w_resp_data_nxt  = i_res_data;
          end else begin
            w_state_nxt     = S_WR_ISSUE;
            w_cmd_valid_nxt = 1'b1;
            w_cmd_op_nxt    = RV_MEM_WRITE;
            w_cmd_addr_nxt  = r_addr;
            w_cmd_data_nxt  = w_merged;
          end
        end
      end

      S_WR_ISSUE: begin
        if (i_cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          if (ACK_EN) begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
            w_resp_addr_nxt  = r_addr;
            w_resp_data_nxt  = r_cmd_data;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end

      S_RESP: begin
        if (i_resp_ready) begin
          w_resp_valid_nxt = 1'b0;
          w_state_nxt      = S_IDLE;
        end
      end

      default: begin
        w_state_nxt      = S_IDLE;
        w_cmd_valid_nxt  = 1'b0;
        w_resp_valid_nxt = 1'b0;
      end
    endcase

    // Handshake-ready flags are registered copies of the upcoming state.
    w_req_ready_nxt = (w_state_nxt == S_IDLE);
    w_res_ready_nxt = (w_state_nxt == S_RD_WAIT);
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_op         <= RV_MEM_READ;
      r_addr       <= '0;
      r_data       <= '0;
      r_mask       <= '0;
      r_req_ready  <= 1'b0;
      r_cmd_valid  <= 1'b0;
      r_cmd_op     <= RV_MEM_READ;
      r_cmd_addr   <= '0;
      r_cmd_data   <= '0;
      r_res_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_op         <= w_op_nxt;
      r_addr       <= w_addr_nxt;
      r_data       <= w_data_nxt;
      r_mask       <= w_mask_nxt;
      r_req_ready  <= w_req_ready_nxt;
      r_cmd_valid  <= w_cmd_valid_nxt;
      r_cmd_op     <= w_cmd_op_nxt;
      r_cmd_addr   <= w_cmd_addr_nxt;
      r_cmd_data   <= w_cmd_data_nxt;
      r_res_ready  <= w_res_ready_nxt;
      r_resp_valid <= w_resp_valid_nxt;
      r_resp_addr  <= w_resp_addr_nxt;
      r_resp_data  <= w_resp_data_nxt;
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_cmd_valid  = r_cmd_valid;
  assign o_cmd_op     = r_cmd_op;
  assign o_cmd_addr   = r_cmd_addr;
  assign o_cmd_data   = r_cmd_data;
  assign o_res_ready  = r_res_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_addr  = r_resp_addr;
  assign o_resp_data  = r_resp_data;

endmodule

// File: tb/tb_rv_mem_rmw_sequencer.sv
// Self-checking bench for rv_mem_rmw_sequencer: directed scenarios plus a random phase,
// checked against a word-array reference model and a single-cycle memory model.
module tb_rv_mem_rmw_sequencer;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam logic OP_RD = 1'b0;
  localparam logic OP_WR = 1'b1;

`ifdef RV_MEM_RMW_WRITE_ACK_EN
  localparam logic ACK = 1'b1;
`else
  localparam logic ACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_op = OP_RD;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [3:0]    req_mask = '0;
  logic          cmd_rdy_dir = 1'b1;
  logic          resp_rdy_dir = 1'b1;
  logic          bp_en = 1'b0;
  logic          bp_cmd = 1'b1;
  logic          bp_resp = 1'b1;
  logic          mem_init = 1'b1;

  logic          cmd_ready, resp_ready;
  logic          req_ready, cmd_valid, cmd_op, res_ready, resp_valid;
  logic [AW-1:0] cmd_addr, resp_addr;
  logic [DW-1:0] cmd_data, resp_data;

  // memory model
  logic [DW-1:0] mem [0:1023];
  logic          res_valid = 1'b0;
  logic          res_op = OP_RD;
  logic [AW-1:0] res_addr = '0;
  logic [DW-1:0] res_data = '0;

  // reference model and bookkeeping
  logic [DW-1:0] ref_mem [0:1023];
  int n_vec = 0, n_miss = 0;
  int cyc = 0, n_rd = 0, n_wr = 0, n_cmd_cyc = 0, n_resp = 0;
  logic [DW-1:0] last_wr_data = '0;
  logic [AW-1:0] last_wr_addr = '0;

  assign cmd_ready  = cmd_rdy_dir  & (bp_en ? bp_cmd  : 1'b1);
  assign resp_ready = resp_rdy_dir & (bp_en ? bp_resp : 1'b1);

  always #5 clk = ~clk;

  rv_mem_rmw_sequencer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_op     (req_op),
    .i_req_addr   (req_addr),
    .i_req_data   (req_data),
    .i_req_mask   (req_mask),
    .o_cmd_valid  (cmd_valid),
    .i_cmd_ready  (cmd_ready),
    .o_cmd_op     (cmd_op),
    .o_cmd_addr   (cmd_addr),
    .o_cmd_data   (cmd_data),
    .i_res_valid  (res_valid),
    .o_res_ready  (res_ready),
    .i_res_op     (res_op),
    .i_res_addr   (res_addr),
    .i_res_data   (res_data),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_addr  (resp_addr),
    .o_resp_data  (resp_data)
  );

  // Single-cycle memory: a read result appears the cycle after the command and is held until taken.
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h5A5A_0000 | 32'(i);
    end
    if (rst) begin
      res_valid <= 1'b0;
    end else begin
      if (res_valid && res_ready) res_valid <= 1'b0;
      if (cmd_valid && cmd_ready) begin
        if (cmd_op == OP_WR) begin
          mem[cmd_addr] <= cmd_data;
        end else begin
          res_valid <= 1'b1;
          res_op    <= OP_RD;
          res_addr  <= cmd_addr;
          res_data  <= mem[cmd_addr];
        end
      end
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid) n_cmd_cyc <= n_cmd_cyc + 1;
    if (cmd_valid && cmd_ready) begin
      if (cmd_op == OP_WR) begin
        n_wr         <= n_wr + 1;
        last_wr_data <= cmd_data;
        last_wr_addr <= cmd_addr;
      end else begin
        n_rd <= n_rd + 1;
      end
    end
    if (resp_valid && resp_ready) n_resp <= n_resp + 1;
  end

  always @(negedge clk) begin
    bp_cmd  <= 1'($urandom_range(0, 1));
    bp_resp <= 1'($urandom_range(0, 1));
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Byte i of the result comes from the new word when mask bit i is set.
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [3:0] m);
    logic [DW-1:0] keep;
    keep = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    return (new_w & keep) | (old_w & ~keep);
  endfunction

  task automatic accept(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [3:0] m, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = a;
    req_data  = d;
    req_mask  = m;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("req_ready_seen", 32'(req_ready), 32'd1);
    step();
    acc = cyc;
    req_valid = 1'b0;
    req_op    = 1'($urandom);
    req_addr  = AW'($urandom);
    req_data  = $urandom;
    req_mask  = 4'($urandom);
  endtask

  // One complete transaction, with expectations taken from the reference array.
  // rlat/ilat: cycle (accept = 0) of the first resp_valid and of req_ready returning.
  task automatic run_req(input logic op, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [3:0] m, output int rlat, output int ilat);
    logic          want_resp;
    logic [DW-1:0] exp_data;
    int exp_rd, exp_wr, r0, w0, p0, acc, n;
    if (op == OP_RD) begin
      want_resp = 1'b1;
      exp_data  = ref_mem[a];
      exp_rd    = 1;
      exp_wr    = 0;
    end else begin
      want_resp = ACK;
      exp_rd    = (m != 4'h0 && m != 4'hF) ? 1 : 0;
      exp_wr    = (m == 4'h0) ? 0 : 1;
      exp_data  = (m == 4'h0) ? '0 : merge(ref_mem[a], d, m);
      if (m != 4'h0) ref_mem[a] = exp_data;
    end
    r0 = n_rd;
    w0 = n_wr;
    p0 = n_resp;
    accept(op, a, d, m, acc);
    rlat = 0;
    if (want_resp) begin
      n = 0;
      while (!resp_valid && n < 200) begin
        step();
        n++;
      end
      check("resp_valid_seen", 32'(resp_valid), 32'd1);
      rlat = cyc - acc + 1;
      check("resp_addr", 32'(resp_addr), 32'(a));
      check("resp_data", resp_data, exp_data);
    end
    n = 0;
    while (!req_ready && n < 200) begin
      step();
      n++;
    end
    check("req_ready_back", 32'(req_ready), 32'd1);
    ilat = cyc - acc + 1;
    check("read_cmds", 32'(n_rd - r0), 32'(exp_rd));
    check("write_cmds", 32'(n_wr - w0), 32'(exp_wr));
    check("responses", 32'(n_resp - p0), 32'(want_resp));
  endtask

  initial begin
    int rl, il, acc, c0, w0, p0, n;
    logic [3:0] m;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h5A5A_0000 | 32'(i);

    // reset state
    repeat (2) step();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rst_res_ready", 32'(res_ready), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_cmd_addr", 32'(cmd_addr), 32'd0);
    check("rst_cmd_data", cmd_data, 32'd0);
    check("rst_resp_addr", 32'(resp_addr), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    mem_init = 1'b0;
    rst = 1'b0;
    step();
    check("req_ready_after_rst", 32'(req_ready), 32'd1);

    // full write then read back
    run_req(OP_WR, 10'h005, 32'hDEAD_BEEF, 4'hF, rl, il);
    check("fullwr_idle_cycle", 32'(il), ACK ? 32'd3 : 32'd2);
    check("fullwr_addr", 32'(last_wr_addr), 32'h005);
    run_req(OP_RD, 10'h005, 32'h0, 4'h0, rl, il);
    check("rd_resp_cycle", 32'(rl), 32'd3);
    check("rd_idle_cycle", 32'(il), 32'd4);

    // partial merge
    run_req(OP_WR, 10'h010, 32'h1122_3344, 4'hF, rl, il);
    run_req(OP_WR, 10'h010, 32'hAABB_CCDD, 4'b0101, rl, il);
    check("partial_idle_cycle", 32'(il), ACK ? 32'd5 : 32'd4);
    check("partial_wr_data", last_wr_data, 32'h11BB_33DD);
    run_req(OP_RD, 10'h010, 32'h0, 4'h0, rl, il);
    check("partial_mem_word", mem[10'h010], 32'h11BB_33DD);

    // zero mask: no memory traffic
    c0 = n_cmd_cyc;
    run_req(OP_WR, 10'h020, 32'hFFFF_FFFF, 4'h0, rl, il);
    check("zero_mask_idle_cycle", 32'(il), ACK ? 32'd2 : 32'd1);
    check("zero_mask_cmd_cycles", 32'(n_cmd_cyc - c0), 32'd0);
    run_req(OP_RD, 10'h020, 32'h0, 4'h0, rl, il);

    // response backpressure
    resp_rdy_dir = 1'b0;
    p0 = n_resp;
    accept(OP_RD, 10'h010, 32'h0, 4'h0, acc);
    n = 0;
    while (!resp_valid && n < 50) begin
      step();
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 32'(resp_valid), 32'd1);
      check("bp_resp_addr", 32'(resp_addr), 32'h010);
      check("bp_resp_data", resp_data, ref_mem[10'h010]);
      check("bp_req_ready", 32'(req_ready), 32'd0);
      if (k < 4) step();
    end
    resp_rdy_dir = 1'b1;
    step();
    check("bp_resp_done", 32'(resp_valid), 32'd0);
    check("bp_req_ready_back", 32'(req_ready), 32'd1);
    check("bp_resp_count", 32'(n_resp - p0), 32'd1);

    // command backpressure on a read
    cmd_rdy_dir = 1'b0;
    accept(OP_RD, 10'h005, 32'h0, 4'h0, acc);
    for (int k = 0; k < 3; k++) begin
      check("cbp_cmd_valid", 32'(cmd_valid), 32'd1);
      check("cbp_cmd_op", 32'(cmd_op), 32'(OP_RD));
      check("cbp_cmd_addr", 32'(cmd_addr), 32'h005);
      step();
    end
    cmd_rdy_dir = 1'b1;
    n = 0;
    while (!resp_valid && n < 50) begin
      step();
      n++;
    end
    check("cbp_resp_cycle", 32'(cyc - acc + 1), 32'd6);
    check("cbp_resp_data", resp_data, ref_mem[10'h005]);
    step();

    // reset while waiting for the read half of a partial write
    w0 = n_wr;
    accept(OP_WR, 10'h010, 32'hCAFE_F00D, 4'b0011, acc);
    step();
    check("rw_in_rd_wait", 32'(res_ready), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rw_cmd_valid", 32'(cmd_valid), 32'd0);
    check("rw_res_ready", 32'(res_ready), 32'd0);
    check("rw_resp_valid", 32'(resp_valid), 32'd0);
    check("rw_req_ready_low", 32'(req_ready), 32'd0);
    step();
    check("rw_req_ready", 32'(req_ready), 32'd1);
    repeat (4) step();
    check("rw_no_write", 32'(n_wr - w0), 32'd0);
    check("rw_mem_unchanged", mem[10'h010], ref_mem[10'h010]);
    run_req(OP_RD, 10'h010, 32'h0, 4'h0, rl, il);

    // write acknowledge
    p0 = n_resp;
    run_req(OP_WR, 10'h0FF, 32'h1234_5678, 4'hF, rl, il);
    check("ack_resp_count", 32'(n_resp - p0), 32'(ACK));

    // random traffic with backpressure on both streams
    bp_en = 1'b1;
    for (int k = 0; k < 60; k++) begin
      case ($urandom_range(0, 3))
        0:       m = 4'h0;
        1:       m = 4'hF;
        default: m = 4'($urandom);
      endcase
      run_req(1'($urandom), 10'h040 + AW'($urandom_range(0, 15)), $urandom, m, rl, il);
    end
    bp_en = 1'b0;
    step();
    for (int a = 'h40; a < 'h50; a++) check("final_mem", mem[a], ref_mem[a]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/rv_mem_rmw_sequencer.md
# rv_mem_rmw_sequencer

Byte-masked request front end for the single-cycle block memory stage.
- Accepts read and byte-masked write requests and turns them into plain word-level read/write commands on an `rv_mem` stream.
- Partial writes become a read-modify-write: read the old word, merge, write back.
- Sits directly upstream of the memory: drives its command stream and consumes its result stream.
- The attached memory is instantiated with write results disabled, so only reads return a result.

## Interface
Parameters:
- `DATA_WIDTH`, 32, word width. Must be a multiple of 8 and must equal the `rv_mem` interface `DATA_WIDTH`.
- `ADDR_WIDTH`, 10, word address width. Must equal the `rv_mem` interface `ADDR_WIDTH`.
- `MASK_WIDTH`, `DATA_WIDTH/8`, byte-enable width. Derived; not overridden.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request valid.
- `req_ready`  out  1  request accepted when `req_valid && req_ready`.
- `req_op`  in  `rv_mem` op  `RV_MEM_READ` / `RV_MEM_WRITE`.
- `req_addr`  in  `ADDR_WIDTH`  word address.
- `req_data`  in  `DATA_WIDTH`  write data.
- `req_mask`  in  `MASK_WIDTH`  byte enables. Bit i covers `data[8i+7:8i]`; ignored for reads.
- `command`  `rv_mem.out`  -  to memory: valid, ready, op, addr, data.
- `result`  `rv_mem.in`  -  from memory: valid, ready, op, addr, data.
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  response consumer ready.
- `resp_addr`  out  `ADDR_WIDTH`  address of the completed request.
- `resp_data`  out  `DATA_WIDTH`  read data, or merged write data (ack mode only).

## Operation
- One transaction in flight; all outputs registered.
- FSM states: IDLE, RD_ISSUE, RD_WAIT, WR_ISSUE, RESP.
- IDLE: `req_ready`=1. On accept, latch op/addr/data/mask, then:
  - read → RD_ISSUE
  - write with mask all-ones → WR_ISSUE, write data = `req_data`
  - write with 0 < mask < all-ones → RD_ISSUE
  - write with mask = 0 → no memory traffic; IDLE, or RESP under ack mode
- RD_ISSUE: `command.valid`=1, op=READ, addr=latched. On `command.ready` → RD_WAIT.
- RD_WAIT: `result.ready`=1. On `result.valid`:
  - latched read → capture `result.data` → RESP
  - partial write → merged byte i = mask[i] ? new byte : old byte → WR_ISSUE
- WR_ISSUE: `command.valid`=1, op=WRITE, data=merged. On `command.ready` → IDLE, or RESP under ack mode.
- RESP: `resp_valid`=1. Holds addr/data stable until `resp_ready`, then → IDLE.
- `result.ready` is 0 outside RD_WAIT. `command` fields are stable while valid and not yet ready.
- Reset values:
  - state IDLE
  - `req_ready`=0 during reset, 1 the cycle after
  - `command.valid`=0, `result.ready`=0, `resp_valid`=0
  - `command.addr`/`data`, `resp_addr`/`resp_data` = 0
- Reset mid-transaction abandons it with no retry. An in-flight memory result arriving after reset is dropped, because `result.ready`=0.

## Timing
- Accept at cycle 0.
- Read: `command.valid` at cycle 1. With memory ready, `result.valid` at cycle 2 and `resp_valid` at cycle 3. Next accept at cycle 4 if `resp_ready`=1.
- Full write: `command.valid` at cycle 1, IDLE at cycle 2. Issue rate is 1 write per 2 cycles.
- Partial write: read at cycle 1, result at cycle 2, write `command.valid` at cycle 3, IDLE at cycle 4.
- Each backpressure cycle (`command.ready`=0, `result.valid`=0, `resp_ready`=0) adds exactly one cycle in the stalled state.
- No combinational path from `req_*`, `result.*` or `resp_ready` to any output.

## Configuration
- `RV_MEM_RMW_WRITE_ACK_EN` defined:
  - every accepted write, including mask=0, ends in RESP with `resp_data` = the word written.
  - for mask=0 writes, no memory access occurs and `resp_data` = 0.
- `RV_MEM_RMW_WRITE_ACK_EN` not defined: writes never raise `resp_valid`; only reads produce responses.

## Test plan
- Read after full write: write addr 0x005 data 0xDEADBEEF mask 0xF, then read 0x005 → exactly one write command, then `resp_data`=0xDEADBEEF, `resp_addr`=0x005, `resp_valid` at cycle 3 after read accept.
- Partial merge: preload 0x010=0x11223344; write 0xAABBCCDD mask 0b0101 → read then write of 0x11BB33DD; subsequent read returns 0x11BB33DD.
- Zero mask: write 0x020 mask 0 → no `command.valid` asserted; `req_ready` back at 1 next cycle; contents of 0x020 unchanged.
- Backpressure: hold `resp_ready`=0 for 5 cycles on a read → `resp_valid`, `resp_addr`, `resp_data` stable throughout; `req_ready`=0; completes the cycle `resp_ready` rises. Repeat with `command.ready` low 3 cycles → command fields stable.
- Reset in RD_WAIT: assert `rst` one cycle during a partial write → no write command issued afterwards, all valids 0, memory word unchanged, next request served normally.
- Ack macro: with `RV_MEM_RMW_WRITE_ACK_EN`, full write 0x0FF=0x12345678 → one response with `resp_data`=0x12345678. Without the macro → zero responses.
